// File: rtl/wb_uart_rx.sv
// ============================================================================
// Module   : wb_uart_rx
// Purpose  : 8N1 UART receiver with a byte FIFO drained over a Wishbone pop port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_uart_rx #(
   parameter int BAUD_DIV_RATE  = 2604,
   parameter int BAUD_DIV_WIDTH = 12,
   parameter int FIFO_AW        = 4
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       uart_rx,
   input  logic       i_wb_cyc,
   input  logic       i_wb_stb,
   output logic [7:0] o_wb_data,
   output logic       o_wb_ack,
   output logic       o_wb_stall,
   output logic       o_rx_ready,
   output logic       o_frame_err,
   output logic       o_overrun
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [BAUD_DIV_WIDTH-1:0] BAUD_RELOAD = BAUD_DIV_WIDTH'(BAUD_DIV_RATE - 1);
   localparam logic [BAUD_DIV_WIDTH-1:0] BAUD_HALF   = BAUD_DIV_WIDTH'((BAUD_DIV_RATE >> 1) - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic                      rx_meta;
   logic                      rx_s;
   logic [BAUD_DIV_WIDTH-1:0] baud_cnt;
   logic [2:0]                bit_cnt;
   logic [7:0]                shift_reg;
   logic                      tick;
   logic                      stop_tick;
   logic                      push_req;
   logic                      push;
   logic                      pop;
   logic                      empty;
   logic                      full;
   logic [FIFO_AW:0]          wr_ptr;
   logic [FIFO_AW:0]          rd_ptr;
   logic [7:0]                mem [DEPTH];
   logic                      unused_cyc;

   // The master ties cyc to stb, so only stb qualifies a pop.
   assign unused_cyc = i_wb_cyc;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
      end
   end

   assign tick = (baud_cnt == '0);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!rx_s) state_nxt = START;
         START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
         DATA:      if (tick && (bit_cnt == 3'd7)) state_nxt = STOP;
         STOP:      if (tick) state_nxt = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rx_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // First tick lands mid start bit; later ticks land mid each following bit.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         if (state == IDLE) begin
            if (!rx_s) baud_cnt <= BAUD_HALF;
         end else if (tick) begin
            baud_cnt <= BAUD_RELOAD;
         end else begin
            baud_cnt <= baud_cnt - 1'b1;
         end
         if ((state == START) && tick) bit_cnt <= '0;
         if ((state == DATA) && tick) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
         end
      end
   end

   assign stop_tick = (state == STOP) && tick;
   assign push_req  = stop_tick && rx_s;
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign pop       = i_wb_stb && !empty;
   // A pop in the same cycle frees the slot the push is about to use.
   assign push      = push_req && (!full || pop);

   assign o_wb_stall = empty;
   assign o_rx_ready = !empty;

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= shift_reg;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_wb_data   <= '0;
         o_wb_ack    <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            o_wb_data <= mem[rd_ptr[FIFO_AW-1:0]];
         end
         o_wb_ack    <= pop;
         o_frame_err <= stop_tick && !rx_s;
         o_overrun   <= push_req && full && !pop;
      end
   end

endmodule

`default_nettype wire
